// File: rtl/mshr_refill_responder.sv
// Queues MSHR line-read requests and refills each as 8 in-order 64-bit beats into a 512-bit line.
// Response 11 cycles after accept at best; req_ready falls only when the queue is full; no response backpressure.
module mshr_refill_responder #(
  parameter int DEPTH   = 4,
  parameter int BEATS   = 8,
  parameter int PADDR_W = 40,
  parameter int MSHR_W  = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [PADDR_W-1:0]      i_req_paddr,
  input  logic [MSHR_W-1:0]       i_req_mshrid,
  output logic                    o_mem_rd_valid,
  input  logic                    i_mem_rd_ready,
  output logic [PADDR_W-1:0]      o_mem_rd_addr,
  input  logic                    i_mem_rdata_valid,
  input  logic [63:0]             i_mem_rdata,
  output logic                    o_resp_valid,
  output logic [MSHR_W-1:0]       o_resp_mshrid,
  output logic [511:0]            o_resp_data,
  output logic [$clog2(DEPTH):0]  o_queue_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = PADDR_W - 6;

  typedef struct packed {
    logic [LW-1:0]     line;
    logic [MSHR_W-1:0] id;
  } qent_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_t;

  qent_t          r_q [DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  state_t         r_state;
  state_t         w_next;
  logic [LW-1:0]  r_cur_line;
  logic [MSHR_W-1:0] r_cur_id;
  logic [3:0]     r_issue_cnt;
  logic [3:0]     r_recv_cnt;
  logic [511:0]   r_resp_data;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_issue_fire;
  logic           w_recv_fire;
  logic           w_unused;

  // Line offset bits are meaningless for a whole-line fetch.
  assign w_unused = ^i_req_paddr[5:0];

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_req_ready = ~w_full & ~i_reset;
  assign w_push      = i_req_valid & o_req_ready;
  assign o_queue_cnt = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_q[r_wr_ptr[AW-1:0]] <= '{line: i_req_paddr[PADDR_W-1:6], id: i_req_mshrid};
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // RESP is entered on the cycle the last beat lands, not one cycle later.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_FETCH;
      S_FETCH: if (w_recv_fire && (r_recv_cnt == 4'(BEATS - 1))) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_rd_valid = 1'b0;
    o_mem_rd_addr  = '0;
    o_resp_valid   = 1'b0;
    w_pop          = 1'b0;
    w_issue_fire   = 1'b0;
    w_recv_fire    = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = ~w_empty;
      S_FETCH: begin
        o_mem_rd_valid = (r_issue_cnt < 4'(BEATS));
        if (o_mem_rd_valid) o_mem_rd_addr = {r_cur_line, r_issue_cnt[2:0], 3'b000};
        w_issue_fire   = o_mem_rd_valid & i_mem_rd_ready;
        w_recv_fire    = i_mem_rdata_valid & (r_recv_cnt < r_issue_cnt);
      end
      S_RESP:  o_resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cur_line  <= '0;
      r_cur_id    <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_resp_data <= '0;
    end else begin
      if (w_pop) begin
        r_cur_line  <= r_q[r_rd_ptr[AW-1:0]].line;
        r_cur_id    <= r_q[r_rd_ptr[AW-1:0]].id;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
        r_resp_data <= '0;
      end
      if (w_issue_fire) r_issue_cnt <= r_issue_cnt + 4'd1;
      if (w_recv_fire) begin
        r_resp_data[{r_recv_cnt[2:0], 6'd0} +: 64] <= i_mem_rdata;
        r_recv_cnt <= r_recv_cnt + 4'd1;
      end
    end
  end

  assign o_resp_mshrid = r_cur_id;
  assign o_resp_data   = r_resp_data;

endmodule

// File: tb/tb_mshr_refill_responder.sv
// Directed bench for mshr_refill_responder with a latency-configurable in-order memory model.
module tb_mshr_refill_responder;
  localparam int PW = 40;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [PW-1:0] req_paddr;
  logic [MW-1:0] req_id;
  logic          mem_rd_valid;
  logic          mem_rd_ready;
  logic [PW-1:0] mem_rd_addr;
  logic          mem_rdata_valid;
  logic [63:0]   mem_rdata;
  logic          resp_valid;
  logic [MW-1:0] resp_mshrid;
  logic [511:0]  resp_data;
  logic [2:0]    queue_cnt;

  mshr_refill_responder #(.DEPTH(4), .BEATS(8), .PADDR_W(PW), .MSHR_W(MW)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_paddr(req_paddr), .i_req_mshrid(req_id),
    .o_mem_rd_valid(mem_rd_valid), .i_mem_rd_ready(mem_rd_ready), .o_mem_rd_addr(mem_rd_addr),
    .i_mem_rdata_valid(mem_rdata_valid), .i_mem_rdata(mem_rdata),
    .o_resp_valid(resp_valid), .o_resp_mshrid(resp_mshrid), .o_resp_data(resp_data),
    .o_queue_cnt(queue_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: rdy_mode 0=always ready, 1=toggle, 2=never; lat_mode 0=1 cycle, 1=random 1..5, 2=4 cycles.
  int            rdy_mode = 0;
  int            lat_mode = 0;
  bit            use_addr = 0;
  logic [63:0]   pend_d[$];
  int            pend_t[$];
  int            last_due = 0;
  logic [PW-1:0] addr_log[$];
  logic          mv = 1'b0;
  logic [63:0]   md = '0;
  logic          spur_v = 1'b0;
  bit            tog = 0;
  int            beats_out = 0;
  int            stall_viol = 0;
  bit            prev_stall = 0;
  logic [PW-1:0] prev_addr = '0;

  assign mem_rdata_valid = mv | spur_v;
  assign mem_rdata       = mv ? md : 64'hDEAD_BEEF_DEAD_BEEF;

  function automatic logic [63:0] beat_data(input logic [PW-1:0] a, input bit ua);
    logic [63:0] d;
    d = 64'h1111_1111_1111_1111 * 64'(a[5:3]);
    if (ua) d = d ^ {24'h0, a};
    return d;
  endfunction

  function automatic logic [511:0] line_exp(input logic [PW-1:0] a, input bit ua);
    logic [511:0] l;
    logic [PW-1:0] base;
    base = {a[PW-1:6], 6'd0};
    for (int i = 0; i < 8; i++) l[64*i +: 64] = beat_data(base + PW'(8*i), ua);
    return l;
  endfunction

  always @(negedge clk) begin
    logic rdy;
    int   due;
    mv = 1'b0;
    if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
      mv = 1'b1;
      md = pend_d.pop_front();
      void'(pend_t.pop_front());
      beats_out++;
    end
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       begin tog = ~tog; rdy = tog; end
      default: rdy = 1'b0;
    endcase
    mem_rd_ready = rdy;
    if (prev_stall && mem_rd_valid && (mem_rd_addr !== prev_addr)) stall_viol++;
    prev_stall = mem_rd_valid && !rdy;
    prev_addr  = mem_rd_addr;
    if (mem_rd_valid && rdy) begin
      case (lat_mode)
        0:       due = cyc + 1;
        1:       due = cyc + int'($urandom_range(5, 1));
        default: due = cyc + 4;
      endcase
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_t.push_back(due);
      pend_d.push_back(beat_data(mem_rd_addr, use_addr));
      addr_log.push_back(mem_rd_addr);
    end
  end

  logic [MW-1:0]  rid_q[$];
  logic [511:0]   rdat_q[$];
  int             rcyc_q[$];
  always @(negedge clk) begin
    if (resp_valid) begin
      rid_q.push_back(resp_mshrid);
      rdat_q.push_back(resp_data);
      rcyc_q.push_back(cyc);
    end
  end

  task automatic clear_logs();
    rid_q.delete(); rdat_q.delete(); rcyc_q.delete(); addr_log.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called just after a negedge; returns the cycle in which the handshake happened.
  task automatic send(input logic [PW-1:0] a, input logic [MW-1:0] id, output int acc_cyc);
    req_valid = 1'b1; req_paddr = a; req_id = id;
    acc_cyc = -1;
    for (int t = 0; t < 300; t++) begin
      if (req_ready) begin acc_cyc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (acc_cyc < 0) begin
      errors++;
      $display("FAIL send_timeout: id %0d never accepted within 300 cycles", id);
    end
  endtask

  task automatic wait_resp(input int n, input int budget);
    int t = 0;
    while (rid_q.size() < n && t < budget) begin @(negedge clk); t++; end
    checks++;
    if (rid_q.size() < n) begin
      errors++;
      $display("FAIL resp_timeout: got %0d responses, required %0d", rid_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++; if (req_ready !== 1'b0)    begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (mem_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_rd_valid: got %b want 0", mem_rd_valid); end
    checks++; if (mem_rd_addr !== '0)    begin errors++; $display("FAIL rst_mem_rd_addr: got %h want 0", mem_rd_addr); end
    checks++; if (resp_valid !== 1'b0)   begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_mshrid !== '0)    begin errors++; $display("FAIL rst_resp_mshrid: got %h want 0", resp_mshrid); end
    checks++; if (resp_data !== '0)      begin errors++; $display("FAIL rst_resp_data: got nonzero want 0"); end
    checks++; if (queue_cnt !== 3'd0)    begin errors++; $display("FAIL rst_queue_cnt: got %0d want 0", queue_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1)    begin errors++; $display("FAIL post_rst_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_single();
    int n;
    clear_logs(); rdy_mode = 0; lat_mode = 0; use_addr = 0;
    send(40'h00_8000_1040, 4'd2, n);
    wait_resp(1, 40);
    checks++; if (addr_log.size() != 8) begin errors++; $display("FAIL single_beat_count: got %0d want 8", addr_log.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (addr_log[i] !== 40'h00_8000_1040 + PW'(8*i)) begin
        errors++; $display("FAIL single_addr%0d: got %h want %h", i, addr_log[i], 40'h00_8000_1040 + PW'(8*i));
      end
    end
    checks++; if (rcyc_q[0] != n + 11) begin errors++; $display("FAIL single_latency: resp in cycle %0d want %0d", rcyc_q[0], n + 11); end
    checks++; if (rid_q[0] !== 4'd2) begin errors++; $display("FAIL single_id: got %0d want 2", rid_q[0]); end
    checks++; if (rdat_q[0] !== line_exp(40'h00_8000_1040, 0)) begin errors++; $display("FAIL single_data: got %h want %h", rdat_q[0], line_exp(40'h00_8000_1040, 0)); end
    idle(4);
    checks++; if (rid_q.size() != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", rid_q.size()); end
    checks++; if (queue_cnt !== 3'd0 || mem_rd_valid !== 1'b0) begin errors++; $display("FAIL single_idle: queue_cnt %0d mem_rd_valid %b want 0 0", queue_cnt, mem_rd_valid); end
  endtask

  task automatic test_offset();
    int n;
    clear_logs(); use_addr = 1;
    send(40'h00_8000_107F, 4'd5, n);
    wait_resp(1, 40);
    checks++; if (addr_log[0] !== 40'h00_8000_1040) begin errors++; $display("FAIL offset_first_addr: got %h want 8000_1040", addr_log[0]); end
    checks++; if (addr_log[7] !== 40'h00_8000_1078) begin errors++; $display("FAIL offset_last_addr: got %h want 8000_1078", addr_log[7]); end
    checks++; if (rid_q[0] !== 4'd5 || rdat_q[0] !== line_exp(40'h00_8000_1040, 1)) begin errors++; $display("FAIL offset_resp: id %0d data %h", rid_q[0], rdat_q[0]); end
    idle(3);
  endtask

  task automatic test_queue_full();
    int n, acc;
    logic [PW-1:0] base;
    logic [MW-1:0] exp_id[6];
    logic [PW-1:0] exp_a[6];
    clear_logs(); use_addr = 1; rdy_mode = 2; base = 40'h12_3400_0000;
    send(40'h55_0000_0000, 4'd15, n);
    idle(2);
    checks++; if (queue_cnt !== 3'd0) begin errors++; $display("FAIL qfull_blocker_popped: queue_cnt %0d want 0", queue_cnt); end
    acc = 0;
    req_valid = 1'b1; req_paddr = base; req_id = 4'd0;
    for (int t = 0; t < 10; t++) begin
      if (req_ready) acc++;
      @(negedge clk);
      if (acc < 5) begin req_paddr = base + PW'(64*acc); req_id = MW'(acc); end
      else req_valid = 1'b0;
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL qfull_accepts: got %0d want 4", acc); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL qfull_ready: got %b want 0", req_ready); end
    checks++; if (queue_cnt !== 3'd4) begin errors++; $display("FAIL qfull_cnt: got %0d want 4", queue_cnt); end
    rdy_mode = 0;
    send(base + PW'(64*4), 4'd4, n);
    wait_resp(6, 120);
    exp_id[0] = 4'd15; exp_a[0] = 40'h55_0000_0000;
    for (int k = 0; k < 5; k++) begin exp_id[k+1] = MW'(k); exp_a[k+1] = base + PW'(64*k); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (rid_q[k] !== exp_id[k] || rdat_q[k] !== line_exp(exp_a[k], 1)) begin
        errors++; $display("FAIL qfull_order%0d: id %0d want %0d, data match %b", k, rid_q[k], exp_id[k], rdat_q[k] === line_exp(exp_a[k], 1));
      end
    end
    idle(3);
  endtask

  task automatic test_toggle();
    int n;
    clear_logs(); use_addr = 1; rdy_mode = 1; lat_mode = 1; stall_viol = 0;
    send(40'h03_4567_89C0, 4'd9, n);
    wait_resp(1, 200);
    idle(20);
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL toggle_addr_stable: %0d changes while stalled, want 0", stall_viol); end
    checks++; if (rid_q.size() != 1) begin errors++; $display("FAIL toggle_pulses: got %0d want 1", rid_q.size()); end
    checks++; if (rid_q[0] !== 4'd9 || rdat_q[0] !== line_exp(40'h03_4567_89C0, 1)) begin errors++; $display("FAIL toggle_resp: id %0d data %h", rid_q[0], rdat_q[0]); end
    rdy_mode = 0; lat_mode = 0;
  endtask

  task automatic test_spurious();
    int n;
    clear_logs(); use_addr = 1;
    spur_v = 1'b1; idle(3); spur_v = 1'b0;
    checks++; if (queue_cnt !== 3'd0 || resp_valid !== 1'b0 || mem_rd_valid !== 1'b0) begin errors++; $display("FAIL spur_idle: cnt %0d resp %b rd %b want 0 0 0", queue_cnt, resp_valid, mem_rd_valid); end
    send(40'h00_0ABC_0100, 4'd6, n);
    while (cyc < n + 11) @(negedge clk);
    spur_v = 1'b1; idle(2); spur_v = 1'b0;
    send(40'h00_0ABC_0200, 4'd7, n);
    wait_resp(2, 40);
    checks++; if (rid_q[0] !== 4'd6 || rdat_q[0] !== line_exp(40'h00_0ABC_0100, 1)) begin errors++; $display("FAIL spur_first: id %0d data %h", rid_q[0], rdat_q[0]); end
    checks++; if (rid_q[1] !== 4'd7 || rdat_q[1] !== line_exp(40'h00_0ABC_0200, 1)) begin errors++; $display("FAIL spur_second: id %0d data %h", rid_q[1], rdat_q[1]); end
    idle(3);
  endtask

  task automatic test_reset_mid();
    int n, t, b0;
    bit bad;
    clear_logs(); use_addr = 1; rdy_mode = 0; lat_mode = 2;
    b0 = beats_out;
    req_valid = 1'b1;
    req_paddr = 40'h00_7700_0000; req_id = 4'd1; @(negedge clk);
    req_paddr = 40'h00_7700_0040; req_id = 4'd2; @(negedge clk);
    req_paddr = 40'h00_7700_0080; req_id = 4'd3; @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (beats_out - b0 < 3 && t < 40) begin @(negedge clk); t++; end
    @(negedge clk);
    checks++; if (queue_cnt !== 3'd2) begin errors++; $display("FAIL rmid_queued: queue_cnt %0d want 2", queue_cnt); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0 || mem_rd_valid !== 1'b0 || mem_rd_addr !== '0) begin errors++; $display("FAIL rmid_req_mem: ready %b rd_valid %b addr %h want 0 0 0", req_ready, mem_rd_valid, mem_rd_addr); end
    checks++; if (resp_valid !== 1'b0 || resp_mshrid !== '0 || resp_data !== '0) begin errors++; $display("FAIL rmid_resp: valid %b id %0d data nonzero %b", resp_valid, resp_mshrid, resp_data !== '0); end
    checks++; if (queue_cnt !== 3'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", queue_cnt); end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid || mem_rd_valid || queue_cnt != 0) bad = 1;
    end
    checks++; if (bad || rid_q.size() != 0) begin errors++; $display("FAIL rmid_quiet: activity after reset %b, responses %0d want 0", bad, rid_q.size()); end
    lat_mode = 0;
    send(40'h00_7700_0400, 4'd8, n);
    wait_resp(1, 40);
    checks++; if (rid_q[0] !== 4'd8 || rdat_q[0] !== line_exp(40'h00_7700_0400, 1)) begin errors++; $display("FAIL rmid_next: id %0d data %h", rid_q[0], rdat_q[0]); end
    idle(3);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_paddr = '0; req_id = '0;
    test_reset();
    test_single();
    test_offset();
    test_queue_full();
    test_toggle();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
